// File: rtl/mem_stage_unit.sv
// MEM stage of the 16-bit pipelined CPU: branch/call/ret resolution, req/ack data-memory
// handshake with upstream stall, and the MEM/WB register. Optional abort on timeout: MEM_TIMEOUT_EN.
module mem_stage_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Branch,
  input  logic        call,
  input  logic        ret,
  input  logic [2:0]  BranchType,
  input  logic [11:0] Address,
  input  logic [15:0] retAddr,
  input  logic [15:0] pc_addr,
  input  logic        V,
  input  logic        Z,
  input  logic        N,
  input  logic [1:0]  RegDst,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic        run,
  input  logic [3:0]  Rd,
  input  logic [15:0] ALU_result,
  input  logic [15:0] data_r2,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        pc_src,
  output logic [15:0] target_addr,
  output logic        flush,
  output logic [1:0]  wb_RegDst,
  output logic        wb_MemtoReg,
  output logic        wb_RegWrite,
  output logic        wb_run,
  output logic [3:0]  wb_Rd,
  output logic [15:0] wb_ALU_result,
  output logic [15:0] wb_mem_data,
  output logic [15:0] wb_retAddr,
  output logic        mem_err
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   mem_op_s;
  logic   abort_s;
  logic   timeout_hit_s;
  logic   cond_s;
  logic   unused_pc_low_s;

  assign mem_op_s        = MemRead | MemWrite;
  assign unused_pc_low_s = ^pc_addr[11:0];

  // State register
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, handshake request and stall
  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    dmem_req = 1'b0;
    abort_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op_s) begin
          stall    = 1'b1;
          dmem_req = 1'b1;
          state_d  = ST_ACCESS;
        end else begin
          stall    = 1'b0;
        end
      end
      ST_ACCESS: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_d = ST_IDLE;
        end else if (timeout_hit_s) begin
          // abandon the access: release the pipeline and retire a bubble
          abort_s = 1'b1;
          state_d = ST_IDLE;
        end else begin
          stall   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign dmem_we    = dmem_req & MemWrite;
  assign dmem_addr  = ALU_result;
  assign dmem_wdata = data_r2;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CntW-1:0] cnt_q;
  logic            mem_err_q;

  assign timeout_hit_s = (cnt_q == CntW'(TIMEOUT - 1));
  assign mem_err       = mem_err_q;

  // ACCESS-cycle counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      if ((state_q == ST_ACCESS) && !dmem_ack && !timeout_hit_s) begin
        cnt_q <= cnt_q + CntW'(1);
      end else begin
        cnt_q <= '0;
      end
      mem_err_q <= mem_err_q | abort_s;
    end
  end
`else
  localparam int unsigned unused_timeout_p = TIMEOUT;
  assign timeout_hit_s = 1'b0;
  assign mem_err       = 1'b0;
`endif

  // Branch condition from ALU flags
  always_comb begin
    cond_s = 1'b0;
    case (BranchType)
      3'd0:    cond_s = Z;
      3'd1:    cond_s = !Z;
      3'd2:    cond_s = !Z & !(N ^ V);
      3'd3:    cond_s = N ^ V;
      3'd4:    cond_s = !(N ^ V);
      3'd5:    cond_s = Z | (N ^ V);
      3'd6:    cond_s = V;
      3'd7:    cond_s = 1'b1;
      default: cond_s = 1'b0;
    endcase
  end

  assign pc_src      = !stall & ((Branch & cond_s) | call | ret);
  assign flush       = pc_src;
  assign target_addr = ret ? ALU_result : {pc_addr[15:12], Address};

  // MEM/WB pipeline register; a stalled or aborted cycle retires a bubble
  always_ff @(posedge clk) begin
    if (clear) begin
      wb_RegDst     <= 2'd0;
      wb_MemtoReg   <= 1'b0;
      wb_RegWrite   <= 1'b0;
      wb_run        <= 1'b1;
      wb_Rd         <= 4'd0;
      wb_ALU_result <= 16'h0000;
      wb_mem_data   <= 16'h0000;
      wb_retAddr    <= 16'h0000;
    end else begin
      if (!stall && !abort_s) begin
        wb_RegDst     <= RegDst;
        wb_MemtoReg   <= MemtoReg;
        wb_RegWrite   <= RegWrite;
        wb_run        <= run;
        wb_Rd         <= Rd;
        wb_ALU_result <= ALU_result;
        wb_retAddr    <= retAddr;
      end else begin
        wb_RegWrite   <= 1'b0;
        wb_run        <= 1'b1;
      end
      if ((state_q == ST_ACCESS) && dmem_ack) begin
        wb_mem_data <= dmem_rdata;
      end else begin
        wb_mem_data <= wb_mem_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit: table of control-flow / pass-through vectors plus
// hand-written load, store, clear-abort and (with MEM_TIMEOUT_EN) timeout sequences.
module tb_mem_stage_unit;

  logic        clk = 1'b0;
  logic        clear, MemRead, MemWrite, Branch, call, ret;
  logic [2:0]  BranchType;
  logic [11:0] Address;
  logic [15:0] retAddr, pc_addr;
  logic        V, Z, N;
  logic [1:0]  RegDst;
  logic        MemtoReg, RegWrite, run;
  logic [3:0]  Rd;
  logic [15:0] ALU_result, data_r2;
  logic        dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        stall, pc_src, flush;
  logic [15:0] target_addr;
  logic [1:0]  wb_RegDst;
  logic        wb_MemtoReg, wb_RegWrite, wb_run;
  logic [3:0]  wb_Rd;
  logic [15:0] wb_ALU_result, wb_mem_data, wb_retAddr;
  logic        mem_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .clear(clear), .MemRead(MemRead), .MemWrite(MemWrite),
    .Branch(Branch), .call(call), .ret(ret), .BranchType(BranchType),
    .Address(Address), .retAddr(retAddr), .pc_addr(pc_addr),
    .V(V), .Z(Z), .N(N), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .run(run), .Rd(Rd), .ALU_result(ALU_result),
    .data_r2(data_r2), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .stall(stall), .pc_src(pc_src),
    .target_addr(target_addr), .flush(flush), .wb_RegDst(wb_RegDst),
    .wb_MemtoReg(wb_MemtoReg), .wb_RegWrite(wb_RegWrite), .wb_run(wb_run),
    .wb_Rd(wb_Rd), .wb_ALU_result(wb_ALU_result), .wb_mem_data(wb_mem_data),
    .wb_retAddr(wb_retAddr), .mem_err(mem_err)
  );

  typedef struct {
    logic [2:0]  bt;
    logic        br, ca, rt, v, z, n;
    logic [15:0] pc;
    logic [11:0] addr;
    logic [15:0] alu, ra;
    logic [3:0]  rd;
    logic        rw;
    logic        exp_src;
    logic [15:0] exp_tgt;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int stall_cnt;

  initial begin
    clear = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Branch = 1'b0; call = 1'b0; ret = 1'b0;
    BranchType = 3'd0; Address = 12'h000; retAddr = 16'h0000; pc_addr = 16'h0000;
    V = 1'b0; Z = 1'b0; N = 1'b0; RegDst = 2'd0; MemtoReg = 1'b0; RegWrite = 1'b0;
    run = 1'b1; Rd = 4'd0; ALU_result = 16'h0000; data_r2 = 16'h0000;
    dmem_rdata = 16'h0000; dmem_ack = 1'b0;

    //         bt   br   ca   rt   v    z    n    pc        addr     alu       ra        rd     rw   src  tgt
    tbl[0]  = '{3'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,12'h000,16'h1234,16'h0000,4'd5, 1'b1,1'b0,16'h0000};
    tbl[1]  = '{3'd3,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,16'h3010,12'h0A0,16'h0001,16'h0000,4'd1, 1'b1,1'b1,16'h30A0};
    tbl[2]  = '{3'd3,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,16'h3010,12'h0A0,16'h0002,16'h0000,4'd2, 1'b0,1'b0,16'h30A0};
    tbl[3]  = '{3'd0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,16'h4000,12'h555,16'h0200,16'h0000,4'd3, 1'b0,1'b1,16'h0200};
    tbl[4]  = '{3'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,16'h5000,12'h123,16'h0000,16'h1005,4'd15,1'b1,1'b1,16'h5123};
    tbl[5]  = '{3'd0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,16'hA000,12'hFFF,16'h00FF,16'h0000,4'd4, 1'b0,1'b1,16'hAFFF};
    tbl[6]  = '{3'd2,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,16'h1000,12'h010,16'h0000,16'h0000,4'd6, 1'b1,1'b1,16'h1010};
    tbl[7]  = '{3'd5,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,16'h2000,12'h020,16'h0000,16'h0000,4'd7, 1'b1,1'b0,16'h2020};
    tbl[8]  = '{3'd6,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,16'h3000,12'h030,16'h0000,16'h0000,4'd8, 1'b0,1'b1,16'h3030};
    tbl[9]  = '{3'd7,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,16'h4000,12'h040,16'h0000,16'h0000,4'd9, 1'b1,1'b1,16'h4040};
    tbl[10] = '{3'd7,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h5000,12'h050,16'h0000,16'h0000,4'd10,1'b1,1'b0,16'h5050};
    tbl[11] = '{3'd1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,16'h6000,12'h060,16'h0000,16'h2222,4'd11,1'b0,1'b1,16'h6060};
    tbl[12] = '{3'd4,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,16'h7000,12'h070,16'h0000,16'h0000,4'd12,1'b1,1'b0,16'h7070};

    tick(); tick();
    chk("rst_wb_run", {15'd0, wb_run}, 16'h0001);
    chk("rst_wb_RegWrite", {15'd0, wb_RegWrite}, 16'h0000);
    chk("rst_wb_Rd", {12'd0, wb_Rd}, 16'h0000);
    chk("rst_wb_mem_data", wb_mem_data, 16'h0000);
    chk("rst_stall", {15'd0, stall}, 16'h0000);
    chk("rst_dmem_req", {15'd0, dmem_req}, 16'h0000);
    chk("rst_mem_err", {15'd0, mem_err}, 16'h0000);
    clear = 1'b0;

    for (int i = 0; i < 13; i++) begin
      BranchType = tbl[i].bt; Branch = tbl[i].br; call = tbl[i].ca; ret = tbl[i].rt;
      V = tbl[i].v; Z = tbl[i].z; N = tbl[i].n; pc_addr = tbl[i].pc; Address = tbl[i].addr;
      ALU_result = tbl[i].alu; retAddr = tbl[i].ra; Rd = tbl[i].rd; RegWrite = tbl[i].rw;
      RegDst = 2'(i); MemtoReg = i[0];
      #1;
      chk($sformatf("v%0d_stall", i), {15'd0, stall}, 16'h0000);
      chk($sformatf("v%0d_pc_src", i), {15'd0, pc_src}, {15'd0, tbl[i].exp_src});
      chk($sformatf("v%0d_flush", i), {15'd0, flush}, {15'd0, tbl[i].exp_src});
      chk($sformatf("v%0d_target", i), target_addr, tbl[i].exp_tgt);
      tick();
      chk($sformatf("v%0d_wb_Rd", i), {12'd0, wb_Rd}, {12'd0, tbl[i].rd});
      chk($sformatf("v%0d_wb_ALU", i), wb_ALU_result, tbl[i].alu);
      chk($sformatf("v%0d_wb_RegWrite", i), {15'd0, wb_RegWrite}, {15'd0, tbl[i].rw});
      chk($sformatf("v%0d_wb_retAddr", i), wb_retAddr, tbl[i].ra);
      chk($sformatf("v%0d_wb_RegDst", i), {14'd0, wb_RegDst}, {14'd0, 2'(i)});
      chk($sformatf("v%0d_wb_MemtoReg", i), {15'd0, wb_MemtoReg}, {15'd0, i[0]});
    end
    Branch = 1'b0; call = 1'b0; ret = 1'b0;

    // Load, ack in the 4th cycle counting the issue cycle
    MemRead = 1'b1; ALU_result = 16'h0040; Rd = 4'd3; RegWrite = 1'b1; MemtoReg = 1'b1;
    RegDst = 2'd1; Branch = 1'b1; BranchType = 3'd7;
    #1;
    chk("ld_issue_req", {15'd0, dmem_req}, 16'h0001);
    chk("ld_issue_we", {15'd0, dmem_we}, 16'h0000);
    chk("ld_addr", dmem_addr, 16'h0040);
    chk("ld_branch_gated", {15'd0, pc_src}, 16'h0000);
    stall_cnt = (stall === 1'b1) ? 1 : 0;
    Branch = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk($sformatf("ld_bubble%0d_RegWrite", c), {15'd0, wb_RegWrite}, 16'h0000);
      chk($sformatf("ld_bubble%0d_run", c), {15'd0, wb_run}, 16'h0001);
      if (c == 3) begin
        dmem_ack = 1'b1; dmem_rdata = 16'hBEEF;
      end
      #1;
      chk($sformatf("ld_c%0d_req", c), {15'd0, dmem_req}, 16'h0001);
      if (stall === 1'b1) stall_cnt++;
    end
    tick();
    dmem_ack = 1'b0; MemRead = 1'b0;
    chk("ld_stall_cycles", 16'(stall_cnt), 16'd3);
    chk("ld_wb_mem_data", wb_mem_data, 16'hBEEF);
    chk("ld_wb_Rd", {12'd0, wb_Rd}, 16'h0003);
    chk("ld_wb_RegWrite", {15'd0, wb_RegWrite}, 16'h0001);
    chk("ld_wb_MemtoReg", {15'd0, wb_MemtoReg}, 16'h0001);
    #1;
    chk("ld_after_stall", {15'd0, stall}, 16'h0000);

    // Ack while idle must not touch wb_mem_data
    dmem_ack = 1'b1; dmem_rdata = 16'h1111;
    tick();
    dmem_ack = 1'b0;
    chk("idle_ack_ignored", wb_mem_data, 16'hBEEF);

    // Store, ack one cycle after issue
    MemWrite = 1'b1; data_r2 = 16'h00AA; ALU_result = 16'h0080; RegWrite = 1'b0;
    #1;
    chk("st_we", {15'd0, dmem_we}, 16'h0001);
    chk("st_wdata", dmem_wdata, 16'h00AA);
    chk("st_addr", dmem_addr, 16'h0080);
    stall_cnt = (stall === 1'b1) ? 1 : 0;
    tick();
    dmem_ack = 1'b1;
    #1;
    chk("st_ack_we", {15'd0, dmem_we}, 16'h0001);
    if (stall === 1'b1) stall_cnt++;
    tick();
    dmem_ack = 1'b0; MemWrite = 1'b0;
    #1;
    if (stall === 1'b1) stall_cnt++;
    chk("st_stall_cycles", 16'(stall_cnt), 16'd1);

    // Clear in the middle of an access
    MemRead = 1'b1; ALU_result = 16'h0010; RegWrite = 1'b1;
    tick();
    chk("clr_in_access_stall", {15'd0, stall}, 16'h0001);
    clear = 1'b1; MemRead = 1'b0;
    tick();
    clear = 1'b0;
    chk("clr_dmem_req", {15'd0, dmem_req}, 16'h0000);
    chk("clr_stall", {15'd0, stall}, 16'h0000);
    chk("clr_wb_RegWrite", {15'd0, wb_RegWrite}, 16'h0000);
    chk("clr_wb_run", {15'd0, wb_run}, 16'h0001);

`ifdef MEM_TIMEOUT_EN
    // No ack: ACCESS cycles 1..3 stall, the 4th aborts
    MemRead = 1'b1; RegWrite = 1'b1; Rd = 4'd9;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("to_c%0d_stall", c), {15'd0, stall}, (c == 4) ? 16'h0000 : 16'h0001);
      chk($sformatf("to_c%0d_err", c), {15'd0, mem_err}, 16'h0000);
    end
    MemRead = 1'b0;
    tick();
    chk("to_mem_err", {15'd0, mem_err}, 16'h0001);
    chk("to_bubble", {15'd0, wb_RegWrite}, 16'h0000);
    chk("to_idle_req", {15'd0, dmem_req}, 16'h0000);
    tick();
    chk("to_mem_err_sticky", {15'd0, mem_err}, 16'h0001);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("to_err_cleared", {15'd0, mem_err}, 16'h0000);
`else
    // Without the timeout feature an un-acked access keeps stalling
    MemRead = 1'b1;
    for (int c = 1; c <= 6; c++) tick();
    chk("no_to_still_stall", {15'd0, stall}, 16'h0001);
    chk("no_to_mem_err", {15'd0, mem_err}, 16'h0000);
    clear = 1'b1; MemRead = 1'b0;
    tick();
    clear = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
